// File: rtl/pgm_loader.sv
// Byte-stream program loader: parses A5-framed words and writes them into the
// CPU program RAM with slow pg_wr strobes. Define PGM_LOADER_CHECKSUM_EN to add a trailing checksum check.
module pgm_loader #(
  parameter int unsigned MEM_SIZE = 255,
  parameter int unsigned HOLD     = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  input  logic        abort,
  output logic        pgm,
  output logic [15:0] pgm_addr,
  output logic [15:0] pgm_data,
  output logic        pg_wr,
  output logic        cpu_halt,
  output logic        done,
  output logic        error
);

  localparam int unsigned AW = 16;
  localparam int unsigned DW = 16;
  localparam int unsigned BW = 8;
  localparam int unsigned CW = 4;
  localparam int unsigned IW = 2;

  typedef enum logic [2:0] {
    IDLE, HDR, DATA, STROBE, GAP, DONE, ERR
`ifdef PGM_LOADER_CHECKSUM_EN
    , CSUM
`endif
  } state_t;

  state_t         state_q, state_d;
  logic [IW-1:0]  hdr_idx_q, hdr_idx_d;
  logic           lo_phase_q, lo_phase_d;
  logic [BW-1:0]  hi_byte_q, hi_byte_d;
  logic [DW-1:0]  remain_q, remain_d;
  logic [CW-1:0]  hold_q, hold_d;
  logic [AW-1:0]  addr_d;
  logic [DW-1:0]  data_d;
  logic           pg_wr_d, pgm_d, rx_ready_d, done_d, error_d;
`ifdef PGM_LOADER_CHECKSUM_EN
  logic [DW-1:0]  csum_q, csum_d;
`endif

  logic           xfer;
  logic [DW-1:0]  word;
  logic [AW:0]    end_addr;

  assign xfer     = rx_valid && rx_ready;
  assign word     = {hi_byte_q, rx_data};
  // 17-bit last-address of the frame so base+N-1 cannot silently wrap
  assign end_addr = {1'b0, pgm_addr} + {1'b0, word} - (AW+1)'(1);
  assign cpu_halt = pgm;

  // Next-state and datapath
  always_comb begin
    state_d    = state_q;
    hdr_idx_d  = hdr_idx_q;
    lo_phase_d = lo_phase_q;
    hi_byte_d  = hi_byte_q;
    remain_d   = remain_q;
    hold_d     = hold_q;
    addr_d     = pgm_addr;
    data_d     = pgm_data;
`ifdef PGM_LOADER_CHECKSUM_EN
    csum_d     = csum_q;
`endif

    if (abort) begin
      state_d    = IDLE;
      hdr_idx_d  = '0;
      lo_phase_d = 1'b0;
      hold_d     = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (xfer && rx_data == 8'hA5) begin
            state_d   = HDR;
            hdr_idx_d = '0;
`ifdef PGM_LOADER_CHECKSUM_EN
            csum_d    = '0;
`endif
          end
        end
        HDR: begin
          if (xfer) begin
            hdr_idx_d = hdr_idx_q + IW'(1);
            case (hdr_idx_q)
              2'd0:    hi_byte_d = rx_data;
              2'd1:    addr_d    = word;
              2'd2:    hi_byte_d = rx_data;
              default: begin
                remain_d   = word;
                lo_phase_d = 1'b0;
                if (word == '0)                      state_d = DONE;
                else if (end_addr > (AW+1)'(MEM_SIZE)) state_d = ERR;
                else                                 state_d = DATA;
              end
            endcase
          end
        end
        DATA: begin
          if (xfer) begin
            if (!lo_phase_q) begin
              hi_byte_d  = rx_data;
              lo_phase_d = 1'b1;
            end else begin
              data_d     = word;
              lo_phase_d = 1'b0;
              hold_d     = '0;
              state_d    = STROBE;
`ifdef PGM_LOADER_CHECKSUM_EN
              csum_d     = csum_q + word;
`endif
            end
          end
        end
        STROBE: begin
          if (hold_q == CW'(HOLD - 1)) begin
            hold_d  = '0;
            state_d = GAP;
          end else begin
            hold_d  = hold_q + CW'(1);
          end
        end
        GAP: begin
          if (hold_q == CW'(HOLD - 1)) begin
            hold_d   = '0;
            addr_d   = pgm_addr + AW'(1);
            remain_d = remain_q - DW'(1);
            if (remain_q == DW'(1)) begin
`ifdef PGM_LOADER_CHECKSUM_EN
              state_d = CSUM;
`else
              state_d = DONE;
`endif
            end else begin
              state_d = DATA;
            end
          end else begin
            hold_d = hold_q + CW'(1);
          end
        end
`ifdef PGM_LOADER_CHECKSUM_EN
        CSUM: begin
          if (xfer) begin
            if (!lo_phase_q) begin
              hi_byte_d  = rx_data;
              lo_phase_d = 1'b1;
            end else begin
              lo_phase_d = 1'b0;
              state_d    = (word == csum_q) ? DONE : ERR;
            end
          end
        end
`endif
        DONE:    state_d = IDLE;
        ERR:     state_d = ERR;
        default: state_d = IDLE;
      endcase
    end

    // Outputs decoded from the next state so they register alongside it
    pg_wr_d    = (state_d == STROBE);
    done_d     = (state_d == DONE);
    error_d    = (state_d == ERR);
    pgm_d      = (state_d == HDR) || (state_d == DATA) ||
                 (state_d == STROBE) || (state_d == GAP);
    rx_ready_d = (state_d == IDLE) || (state_d == HDR) || (state_d == DATA);
`ifdef PGM_LOADER_CHECKSUM_EN
    pgm_d      = pgm_d || (state_d == CSUM);
    rx_ready_d = rx_ready_d || (state_d == CSUM);
`endif
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      hdr_idx_q  <= '0;
      lo_phase_q <= 1'b0;
      hi_byte_q  <= '0;
      remain_q   <= '0;
      hold_q     <= '0;
      pgm_addr   <= '0;
      pgm_data   <= '0;
      pg_wr      <= 1'b0;
      pgm        <= 1'b0;
      done       <= 1'b0;
      error      <= 1'b0;
      rx_ready   <= 1'b1;
`ifdef PGM_LOADER_CHECKSUM_EN
      csum_q     <= '0;
`endif
    end else begin
      state_q    <= state_d;
      hdr_idx_q  <= hdr_idx_d;
      lo_phase_q <= lo_phase_d;
      hi_byte_q  <= hi_byte_d;
      remain_q   <= remain_d;
      hold_q     <= hold_d;
      pgm_addr   <= addr_d;
      pgm_data   <= data_d;
      pg_wr      <= pg_wr_d;
      pgm        <= pgm_d;
      done       <= done_d;
      error      <= error_d;
      rx_ready   <= rx_ready_d;
`ifdef PGM_LOADER_CHECKSUM_EN
      csum_q     <= csum_d;
`endif
    end
  end

endmodule

// File: tb/tb_pgm_loader.sv
// Scoreboard bench for pgm_loader: frame-level reference model feeds expected
// writes/outcomes; a negedge monitor pops and compares what the loader does.
module tb_pgm_loader;

  localparam int unsigned HOLD     = 4;
  localparam int unsigned MEM_SIZE = 255;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_valid = 1'b0;
  logic        rx_ready;
  logic        abort = 1'b0;
  logic        pgm;
  logic [15:0] pgm_addr;
  logic [15:0] pgm_data;
  logic        pg_wr;
  logic        cpu_halt;
  logic        done;
  logic        error;

  pgm_loader #(.MEM_SIZE(MEM_SIZE), .HOLD(HOLD)) dut (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_ready(rx_ready), .abort(abort), .pgm(pgm), .pgm_addr(pgm_addr),
    .pgm_data(pgm_data), .pg_wr(pg_wr), .cpu_halt(cpu_halt), .done(done),
    .error(error)
  );

  always #5 clk = ~clk;

  int          n_cmp = 0;
  int          n_err = 0;
  logic [31:0] exp_wr[$];
  int          exp_out[$];   // 1 = done, 2 = error
  logic [15:0] fw[$];
  bit          gaps_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic flag(input string name);
    n_cmp++;
    n_err++;
    $display("FAIL %s at %0t", name, $time);
  endtask

  // Monitor
  int          hi_cnt = 0;
  logic        prev_wr = 1'b0;
  logic        prev_err = 1'b0;
  logic [15:0] cur_a, cur_d;
  logic [31:0] mon_e;
  int          mon_o;

  always @(negedge clk) begin
    if (!rst) begin
      hi_cnt   = 0;
      prev_wr  = 1'b0;
      prev_err = 1'b0;
    end else begin
      if (pg_wr) begin
        chk("rx_ready_in_strobe", 32'(rx_ready), 32'd0);
        chk("cpu_halt_in_strobe", 32'(cpu_halt), 32'd1);
        if (!prev_wr) begin
          if (exp_wr.size() == 0) flag("unexpected_write");
          else begin
            mon_e = exp_wr.pop_front();
            chk("wr_addr", 32'(pgm_addr), 32'(mon_e[31:16]));
            chk("wr_data", 32'(pgm_data), 32'(mon_e[15:0]));
          end
          cur_a = pgm_addr;
          cur_d = pgm_data;
        end else begin
          chk("addr_stable", 32'(pgm_addr), 32'(cur_a));
          chk("data_stable", 32'(pgm_data), 32'(cur_d));
        end
        hi_cnt++;
      end else if (prev_wr) begin
        chk("pulse_width", 32'(hi_cnt), 32'(HOLD));
        hi_cnt = 0;
      end
      if (done) begin
        if (exp_out.size() == 0) flag("unexpected_done");
        else begin
          mon_o = exp_out.pop_front();
          chk("outcome_done", 32'(mon_o), 32'd1);
        end
      end
      if (error && !prev_err) begin
        if (exp_out.size() == 0) flag("unexpected_error");
        else begin
          mon_o = exp_out.pop_front();
          chk("outcome_error", 32'(mon_o), 32'd2);
        end
      end
      prev_wr  = pg_wr;
      prev_err = error;
    end
  end

  task automatic send_byte(input logic [7:0] b);
    int waited;
    waited   = 0;
    rx_data  = b;
    rx_valid = 1'b1;
    while (!rx_ready && waited < 500) begin
      @(posedge clk); #1;
      waited++;
    end
    if (!rx_ready) flag("rx_ready_timeout");
    else begin
      @(posedge clk); #1;
    end
    if (gaps_en && $urandom_range(0, 3) == 0) begin
      rx_valid = 1'b0;
      repeat ($urandom_range(1, 2)) @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_drain();
    int w;
    w = 0;
    while ((exp_wr.size() != 0 || exp_out.size() != 0) && w < 3000) begin
      @(posedge clk); #1;
      w++;
    end
    if (exp_wr.size() != 0 || exp_out.size() != 0) begin
      flag("drain_timeout");
      exp_wr.delete();
      exp_out.delete();
    end
  endtask

  task automatic pulse_abort();
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
  endtask

  // Frame-level reference: decide outcome and write list, then stream the bytes
  task automatic run_frame(input logic [15:0] base, input logic [15:0] n,
                           input bit csum_ok, input int garbage);
    int          outcome;
    bit          ovf;
    logic [15:0] sum;
    logic [7:0]  g;
    sum = 16'h0;
    ovf = (n != 0) && (int'(base) + int'(n) - 1 > int'(MEM_SIZE));
    if (n == 0)   outcome = 1;
    else if (ovf) outcome = 2;
    else begin
      for (int i = 0; i < int'(n); i++) begin
        exp_wr.push_back({16'(int'(base) + i), fw[i]});
        sum = sum + fw[i];
      end
`ifdef PGM_LOADER_CHECKSUM_EN
      outcome = csum_ok ? 1 : 2;
`else
      outcome = 1;
`endif
    end
    exp_out.push_back(outcome);

    for (int i = 0; i < garbage; i++) begin
      g = 8'($urandom);
      if (g == 8'hA5) g = 8'h5A;
      send_byte(g);
    end
    send_byte(8'hA5);
    send_byte(base[15:8]);
    send_byte(base[7:0]);
    send_byte(n[15:8]);
    send_byte(n[7:0]);
    if (n != 0 && !ovf) begin
      for (int i = 0; i < int'(n); i++) begin
        send_byte(fw[i][15:8]);
        send_byte(fw[i][7:0]);
      end
`ifdef PGM_LOADER_CHECKSUM_EN
      if (!csum_ok) sum = sum + 16'd1;
      send_byte(sum[15:8]);
      send_byte(sum[7:0]);
`endif
    end
    rx_valid = 1'b0;
    wait_drain();
    if (outcome == 1) begin
      chk("pgm_low_after_done", 32'(pgm), 32'd0);
      chk("error_low_after_done", 32'(error), 32'd0);
    end else begin
      chk("error_sticky", 32'(error), 32'd1);
      chk("rx_ready_in_err", 32'(rx_ready), 32'd0);
      chk("pg_wr_in_err", 32'(pg_wr), 32'd0);
      pulse_abort();
      chk("error_cleared", 32'(error), 32'd0);
      chk("rx_ready_after_abort", 32'(rx_ready), 32'd1);
      chk("pgm_after_abort", 32'(pgm), 32'd0);
    end
  endtask

  initial begin
    int w;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_pg_wr", 32'(pg_wr), 32'd0);
    chk("rst_pgm", 32'(pgm), 32'd0);
    chk("rst_addr", 32'(pgm_addr), 32'd0);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("rst_rx_ready", 32'(rx_ready), 32'd1);
    chk("rst_cpu_halt", 32'(cpu_halt), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_error", 32'(error), 32'd0);
    chk("rst_data", 32'(pgm_data), 32'd0);

    // Two-word frame with continuous rx_valid
    fw = '{16'h1234, 16'hABCD};
    run_frame(16'h0010, 16'd2, 1'b1, 0);
    // Leading junk then an empty frame
    send_byte(8'h00);
    send_byte(8'hFF);
    run_frame(16'h0000, 16'd0, 1'b1, 0);
    // Range overflow and boundaries
    run_frame(16'h00FF, 16'd2, 1'b1, 0);
    fw = '{16'h0F0F};
    run_frame(16'h00FF, 16'd1, 1'b1, 0);
    fw = '{16'h1111, 16'h2222};
    run_frame(16'h00FE, 16'd2, 1'b1, 0);
`ifdef PGM_LOADER_CHECKSUM_EN
    fw = '{16'h1234, 16'hABCD};
    run_frame(16'h0010, 16'd2, 1'b1, 0);
    run_frame(16'h0010, 16'd2, 1'b0, 0);
`endif

    // Abort wins over a simultaneous sync byte
    rx_data = 8'hA5; rx_valid = 1'b1; abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0; rx_valid = 1'b0;
    chk("abort_priority_pgm", 32'(pgm), 32'd0);
    chk("abort_priority_ready", 32'(rx_ready), 32'd1);

    // Abort with a half-received word, then a clean reload
    send_byte(8'hA5); send_byte(8'h00); send_byte(8'h20);
    send_byte(8'h00); send_byte(8'h02); send_byte(8'h11);
    rx_valid = 1'b0;
    chk("pgm_mid_frame", 32'(pgm), 32'd1);
    pulse_abort();
    chk("pgm_after_mid_abort", 32'(pgm), 32'd0);
    fw = '{16'h3344, 16'h5566};
    run_frame(16'h0020, 16'd2, 1'b1, 0);

    // Reset in the middle of a strobe
    exp_wr.push_back({16'h0030, 16'h5555});
    send_byte(8'hA5); send_byte(8'h00); send_byte(8'h30);
    send_byte(8'h00); send_byte(8'h02); send_byte(8'h55); send_byte(8'h55);
    rx_valid = 1'b0;
    w = 0;
    while (!pg_wr && w < 100) begin
      @(posedge clk); #1;
      w++;
    end
    if (!pg_wr) flag("strobe_timeout");
    @(posedge clk); #2;
    rst = 1'b0;
    #1;
    chk("async_rst_pg_wr", 32'(pg_wr), 32'd0);
    chk("async_rst_pgm", 32'(pgm), 32'd0);
    chk("async_rst_cpu_halt", 32'(cpu_halt), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    chk("write_popped_before_rst", 32'(exp_wr.size()), 32'd0);
    exp_wr.delete();
    @(posedge clk); #1;
    chk("rx_ready_after_rst", 32'(rx_ready), 32'd1);
    fw = '{16'hCAFE, 16'hBEEF};
    run_frame(16'h0030, 16'd2, 1'b1, 0);

    // Randomized frames
    for (int k = 0; k < 30; k++) begin
      logic [15:0] b;
      logic [15:0] n;
      gaps_en = ($urandom_range(0, 1) == 1);
      b = 16'($urandom_range(0, 270));
      n = 16'($urandom_range(0, 4));
      fw.delete();
      for (int i = 0; i < 4; i++) fw.push_back(16'($urandom));
      run_frame(b, n, ($urandom_range(0, 3) != 0), $urandom_range(0, 2));
    end
    gaps_en = 1'b0;

    repeat (5) @(posedge clk);
    #1;
    chk("final_wr_queue_empty", 32'(exp_wr.size()), 32'd0);
    chk("final_out_queue_empty", 32'(exp_out.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/pgm_loader.md
PGM_LOADER -- requirements
Module: pgm_loader

Interface
REQ-001 Parameter MEM_SIZE, default 255, highest writable RAM word address.
REQ-002 Parameter HOLD, default 4, cycles pg_wr is held high and then held low per word; legal range 3..15.
REQ-003 clk  input  1  sole clock; all state changes on rising edge.
REQ-004 rst  input  1  asynchronous, active-low reset.
REQ-005 rx_data  input  8  incoming byte stream.
REQ-006 rx_valid  input  1  rx_data valid; a byte transfers on a cycle where rx_valid=1 and rx_ready=1.
REQ-007 rx_ready  output  1  loader can accept a byte.
REQ-008 abort  input  1  synchronous cancel of any load.
REQ-009 pgm  output  1  RAM external-program mode select.
REQ-010 pgm_addr  output  16  RAM program write address.
REQ-011 pgm_data  output  16  RAM program write data.
REQ-012 pg_wr  output  1  RAM write strobe; RAM acts on its rising edge after a 2-flop delay.
REQ-013 cpu_halt  output  1  holds CPU stalled; equals pgm.
REQ-014 done  output  1  one-cycle pulse on successful completion.
REQ-015 error  output  1  sticky load failure flag.

Function
REQ-016 Frame format: sync byte 0xA5, base address (2 bytes, high first), word count N (2 bytes, high first), then N data words (high byte first).
REQ-017 States: IDLE, HDR, DATA, STROBE, GAP, DONE, ERR, plus CSUM when the checksum feature is enabled.
REQ-018 IDLE: rx_ready=1; bytes other than 0xA5 are consumed and discarded; 0xA5 -> HDR with pgm asserted the next cycle.
REQ-019 HDR: accept 4 bytes; after the 4th, N=0 -> DONE; base+N-1 > MEM_SIZE (17-bit compare) -> ERR; else -> DATA.
REQ-020 DATA: accept 2 bytes; after the low byte, latch word into pgm_data, address into pgm_addr, -> STROBE.
REQ-021 STROBE: pg_wr=1 for exactly HOLD cycles, then GAP: pg_wr=0 for exactly HOLD cycles; pgm_addr/pgm_data stable throughout both.
REQ-022 After GAP: pgm_addr increments by 1; remaining count decrements; count 0 -> DONE (or CSUM), else -> DATA.
REQ-023 rx_ready=0 in STROBE, GAP, DONE, ERR; 1 in IDLE, HDR, DATA, CSUM.
REQ-024 DONE: done=1 for one cycle, pgm deasserts, -> IDLE.
REQ-025 ERR: error=1, pgm=0, pg_wr=0, rx_ready=0; remain until abort or reset.
REQ-026 abort=1 in any state -> IDLE next cycle; pg_wr, pgm, and error clear; a partial word is dropped; abort has priority over a simultaneous byte transfer.
REQ-027 pgm_addr wraps modulo 2^16 internally; wrap is unreachable due to REQ-019.

Reset
REQ-028 rst low: state=IDLE; pgm, pg_wr, cpu_halt, done, and error = 0; pgm_addr and pgm_data = 0; counters = 0; rx_ready = 1 after release.
REQ-029 Reset mid-STROBE drops pg_wr immediately (asynchronously); no further writes occur.

Configuration
REQ-030 Macro PGM_LOADER_CHECKSUM_EN defined: after the last GAP -> CSUM; accept 2 bytes (high first) and compare to the 16-bit modulo sum of all data words; match -> DONE, mismatch -> ERR.
REQ-031 PGM_LOADER_CHECKSUM_EN undefined: no CSUM state; the last GAP -> DONE directly; no accumulator is synthesized.

Verification
REQ-032 Stream A5 00 10 00 02 12 34 AB CD -> two pg_wr pulses of HOLD cycles each, at addr 0x0010 with data 0x1234 and at 0x0011 with 0xABCD; done pulses once; pgm low afterward.
REQ-033 Stream 00 FF A5 00 00 00 00 -> leading bytes discarded, no pg_wr, done pulses, error=0.
REQ-034 Stream A5 00 FF 00 02 -> ERR, error=1, rx_ready=0, no pg_wr; then abort -> IDLE, error=0.
REQ-035 rx_valid held high continuously -> rx_ready low through STROBE+GAP (2*HOLD cycles per word); no byte is lost or duplicated.
REQ-036 rst pulled low during STROBE -> pg_wr and pgm go low the same cycle; after release, the next frame loads correctly.
REQ-037 With PGM_LOADER_CHECKSUM_EN: frame 0x1234, 0xABCD followed by checksum BE 01 -> done; the same frame with checksum BE 02 -> error.
